// File: rtl/conv_window_ctrl.sv
// Window sequencer for the 4x4 conv/ReLU datapath.
// Fetches each 4x4 window, captures the result, streams it out.
module conv_window_ctrl #(
    parameter int lenOfInput  = 8,
    parameter int lenOfOutput = 25,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int ADDR_W      = 6,
    parameter int OADDR_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [lenOfInput-1:0]   rd_data,
    output logic [16*lenOfInput-1:0] win_data,
    output logic                    win_valid,
    input  logic [lenOfOutput-1:0]  result_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [lenOfOutput-1:0]  out_data,
    output logic [OADDR_W-1:0]      out_addr
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALC,
        OUT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(IMG_H - 4);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(IMG_W - 4);

    state_t            state;
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] c;
    logic [4:0]        idx;
    logic [ADDR_W-1:0] nr;
    logic [ADDR_W-1:0] nc;
    logic [4:0]        idx_nx;
    logic [OADDR_W-1:0] oidx;

    // pixel address of tap i of the window anchored at (rr, cc)
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [ADDR_W-1:0] rr,
        input logic [ADDR_W-1:0] cc,
        input logic [4:0]        i
    );
        pix_addr = ADDR_W'((32'(rr) + 32'(i[4:2])) * 32'(IMG_W)
                           + 32'(cc) + 32'(i[1:0]));
    endfunction

    // raster-order successor of the current window anchor
    always_comb begin
        nr     = r;
        nc     = c + 1'b1;
        idx_nx = idx + 5'd1;
        oidx   = OADDR_W'(32'(r) * 32'(IMG_W - 3) + 32'(c));
        if (c == C_LAST) begin
            nc = '0;
            nr = r + 1'b1;
        end
    end

    // main sequencer: all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            win_data  <= '0;
            win_valid <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            r         <= '0;
            c         <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        r       <= '0;
                        c       <= '0;
                        idx     <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                FETCH: begin
                    // data for read idx-1 arrives this cycle
                    for (int k = 0; k < 16; k++) begin
                        if (idx == 5'(k + 1)) begin
                            win_data[k*lenOfInput +: lenOfInput] <= rd_data;
                        end
                    end
                    if (idx == 5'd16) begin
                        state     <= CALC;
                        win_valid <= 1'b1;
                        rd_en     <= 1'b0;
                    end else begin
                        idx   <= idx_nx;
                        rd_en <= (idx != 5'd15);
                        if (idx != 5'd15) begin
                            rd_addr <= pix_addr(r, c, idx_nx);
                        end
                    end
                end
                CALC: begin
                    win_valid <= 1'b0;
                    out_data  <= result_in;
                    out_addr  <= oidx;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (r == R_LAST && c == C_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            r       <= nr;
                            c       <= nc;
                            idx     <= '0;
                            rd_en   <= 1'b1;
                            rd_addr <= pix_addr(nr, nc, 5'd0);
                            state   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl with a sync-read
// memory and a +/-1 kernel ReLU datapath model.
module tb_conv_window_ctrl;

    localparam int LI = 8;
    localparam int LO = 25;
    localparam int AW = 6;
    localparam int OW = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [LI-1:0]      rd_data;
    logic [LI-1:0]      rd_q;
    logic [16*LI-1:0]   win_data;
    logic               win_valid;
    logic [LO-1:0]      result_in;
    logic               out_valid;
    logic               out_ready;
    logic [LO-1:0]      out_data;
    logic [OW-1:0]      out_addr;

    int checks = 0;
    int errors = 0;
    int ksgn = 1;
    int acc;
    logic [LI-1:0] mem [64];

    conv_window_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .win_data  (win_data),
        .win_valid (win_valid),
        .result_in (result_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr)
    );

    always #5 clk = ~clk;

    // single-port sync-read feature map
    always @(posedge clk) if (rd_en) rd_q <= mem[rd_addr];
    assign rd_data = rd_q;

    // datapath: every tap weighted by ksgn, then ReLU
    always_comb begin
        acc = 0;
        for (int k = 0; k < 16; k++)
            acc = acc + int'($signed(win_data[k*LI +: LI]));
        acc = acc * ksgn;
        result_in = (acc < 0) ? '0 : LO'(acc);
    end

    // runs the rest of a pass; returns handshake/done/order counts
    task automatic drain(input int first, output int n_hs,
                         output int n_done, output int n_order,
                         output bit tout);
        n_hs = 0;
        n_done = 0;
        n_order = 0;
        tout = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) n_done++;
            if (out_valid && out_ready) begin
                if (out_addr != OW'(first + n_hs)) n_order++;
                n_hs++;
            end
            if (!busy) begin
                tout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, win_valid, out_valid} !== 5'b0) begin
            errors++;
            $display("FAIL rst_flags got %b want 00000",
                     {busy, done, rd_en, win_valid, out_valid});
        end
        checks++;
        if (rd_addr !== '0 || out_addr !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_regs got %0d/%0d/%0d want 0/0/0",
                     rd_addr, out_addr, out_data);
        end
        checks++;
        if (win_data !== '0) begin
            errors++;
            $display("FAIL rst_win got %h want 0", win_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %0d want 0", busy);
        end
    endtask

    task automatic test_full_pass;
        int nrd = 0;
        int first_wv = -1;
        int first_ov = -1;
        int n_hs = 0;
        int n_done = 0;
        int done_k = -1;
        int last_k = -1;
        int exp_d;
        bit tout = 1'b1;
        ksgn = 1;
        out_ready = 1'b1;
        start = 1'b1;
        for (int k = 1; k < 3000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_en && first_ov < 0) nrd++;
            if (win_valid && first_wv < 0) first_wv = k;
            if (out_valid) begin
                if (first_ov < 0) first_ov = k;
                exp_d = 216 + 128 * (n_hs / 5) + 16 * (n_hs % 5);
                checks++;
                if (out_addr !== OW'(n_hs)) begin
                    errors++;
                    $display("FAIL pass_addr got %0d want %0d", out_addr, n_hs);
                end
                checks++;
                if (out_data !== LO'(exp_d)) begin
                    errors++;
                    $display("FAIL pass_data got %0d want %0d", out_data, exp_d);
                end
                n_hs++;
                last_k = k;
            end
            if (done) begin
                n_done++;
                done_k = k;
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_busy got %0d want 1", busy);
                end
            end
            if (!busy) begin
                tout = 1'b0;
                break;
            end
        end
        checks++;
        if (tout) begin
            errors++;
            $display("FAIL pass_timeout got 1 want 0");
        end
        checks++;
        if (nrd != 16) begin
            errors++;
            $display("FAIL first_rd_cycles got %0d want 16", nrd);
        end
        checks++;
        if (first_wv != 18) begin
            errors++;
            $display("FAIL win_valid_lat got %0d want 18", first_wv);
        end
        checks++;
        if (first_ov != 19) begin
            errors++;
            $display("FAIL out_valid_lat got %0d want 19", first_ov);
        end
        checks++;
        if (n_hs != 25 || n_done != 1) begin
            errors++;
            $display("FAIL pass_counts got %0d/%0d want 25/1", n_hs, n_done);
        end
        checks++;
        if (done_k != last_k + 1) begin
            errors++;
            $display("FAIL done_timing got %0d want %0d", done_k, last_k + 1);
        end
    endtask

    task automatic test_backpressure;
        int n_hs, n_done, n_order;
        bit tout;
        bit found = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_addr == OW'(3)) begin
                out_ready = 1'b0;
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_reach got 0 want 1");
        end
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== LO'(264) ||
                out_addr !== OW'(3) || rd_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got v%0d d%0d a%0d rd%0d want v1 d264 a3 rd0",
                         out_valid, out_data, out_addr, rd_en);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || rd_en !== 1'b1 || rd_addr !== AW'(4)) begin
            errors++;
            $display("FAIL bp_release got v%0d rd%0d a%0d want v0 rd1 a4",
                     out_valid, rd_en, rd_addr);
        end
        drain(4, n_hs, n_done, n_order, tout);
        checks++;
        if (tout || n_hs != 21 || n_done != 1 || n_order != 0) begin
            errors++;
            $display("FAIL bp_rest got t%0d hs%0d dn%0d ord%0d want t0 hs21 dn1 ord0",
                     tout, n_hs, n_done, n_order);
        end
    endtask

    task automatic test_relu;
        int n_hs = 0;
        int n_done = 0;
        bit tout = 1'b1;
        ksgn = -1;
        out_ready = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) begin
                checks++;
                if (out_data !== '0) begin
                    errors++;
                    $display("FAIL relu_data got %0d want 0", out_data);
                end
                n_hs++;
            end
            if (done) n_done++;
            if (!busy) begin
                tout = 1'b0;
                break;
            end
        end
        ksgn = 1;
        checks++;
        if (tout || n_hs != 25 || n_done != 1) begin
            errors++;
            $display("FAIL relu_counts got t%0d hs%0d dn%0d want t0 hs25 dn1",
                     tout, n_hs, n_done);
        end
    endtask

    task automatic test_rd_addr;
        int q[$];
        int kq[$];
        int exp4[16] = '{12, 13, 14, 15, 20, 21, 22, 23,
                         28, 29, 30, 31, 36, 37, 38, 39};
        out_ready = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_en) begin
                q.push_back(int'(rd_addr));
                kq.push_back(k);
            end
            if (!busy) break;
        end
        checks++;
        if (q.size() != 400) begin
            errors++;
            $display("FAIL rd_total got %0d want 400", q.size());
        end
        if (q.size() >= 160) begin
            for (int j = 0; j < 16; j++) begin
                checks++;
                if (q[144+j] != exp4[j]) begin
                    errors++;
                    $display("FAIL win9_addr%0d got %0d want %0d",
                             j, q[144+j], exp4[j]);
                end
            end
            checks++;
            if (kq[159] - kq[144] != 15) begin
                errors++;
                $display("FAIL win9_span got %0d want 15", kq[159] - kq[144]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n_hs = 0;
        int n_rd = 0;
        int n_done, n_order, stray;
        bit tout;
        bit hit = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) n_hs++;
            else if (n_hs == 7 && rd_en) n_rd++;
            if (n_rd == 5) begin
                rst = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        @(negedge clk);
        checks++;
        if (!hit || busy !== 1'b0 || rd_en !== 1'b0 ||
            out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got h%0d b%0d rd%0d v%0d d%0d want h1 b0 rd0 v0 d0",
                     hit, busy, rd_en, out_valid, done);
        end
        rst = 1'b0;
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL mid_rst_quiet got %0d want 0", stray);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== '0) begin
            errors++;
            $display("FAIL restart_rd got rd%0d a%0d want rd1 a0", rd_en, rd_addr);
        end
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit || out_addr !== '0 || out_data !== LO'(216)) begin
            errors++;
            $display("FAIL restart_first got h%0d a%0d d%0d want h1 a0 d216",
                     hit, out_addr, out_data);
        end
        drain(1, n_hs, n_done, n_order, tout);
        checks++;
        if (tout || n_hs != 24 || n_done != 1 || n_order != 0) begin
            errors++;
            $display("FAIL restart_rest got t%0d hs%0d dn%0d ord%0d want t0 hs24 dn1 ord0",
                     tout, n_hs, n_done, n_order);
        end
    endtask

    task automatic test_start_ignored;
        int n_hs = 0;
        int n_order = 0;
        int n_done;
        bit tout;
        bit hit = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        for (int k = 1; k < 3000; k++) begin
            @(negedge clk);
            start = (k % 7 == 0);
            if (out_valid) begin
                if (out_addr != OW'(n_hs)) n_order++;
                n_hs++;
            end
            if (done) begin
                start = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit || n_hs != 25 || n_order != 0) begin
            errors++;
            $display("FAIL busy_start got h%0d hs%0d ord%0d want h1 hs25 ord0",
                     hit, n_hs, n_order);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_done got b%0d d%0d want b0 d0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== '0) begin
            errors++;
            $display("FAIL idle_restart got b%0d rd%0d a%0d want b1 rd1 a0",
                     busy, rd_en, rd_addr);
        end
        drain(0, n_hs, n_done, n_order, tout);
        checks++;
        if (tout || n_hs != 25 || n_done != 1 || n_order != 0) begin
            errors++;
            $display("FAIL second_pass got t%0d hs%0d dn%0d ord%0d want t0 hs25 dn1 ord0",
                     tout, n_hs, n_done, n_order);
        end
    endtask

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = LI'(a);
        test_reset();
        test_full_pass();
        test_backpressure();
        test_relu();
        test_rd_addr();
        test_reset_mid();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
